// File: rtl/j_slatchn.sv
// Lane-enabled hold register with optional shadow/commit double buffer and change-detect pulse.
// Latency: 1 cycle from en/commit/clr to q; changed follows the q update in the same cycle.
// Backpressure: none; every en/commit/clr is accepted on the edge it is presented.
module j_slatchn #(
    parameter int                 WIDTH     = 16,
    parameter int                 LANES     = 2,
    parameter int                 DBUF      = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   d,
    input  logic [LANES-1:0]   en,
    input  logic               commit,
    input  logic               clr,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   shadow,
    output logic               pending,
    output logic               changed
);

    // Guard the division so a bad LANES value reports cleanly instead of dividing by zero.
    localparam int LANES_SAFE = (LANES < 1) ? 1 : LANES;
    localparam int LW         = WIDTH / LANES_SAFE;

    generate
        if ((LANES < 1) || ((WIDTH % LANES_SAFE) != 0)) begin : g_bad_cfg
            $error("j_slatchn: WIDTH must be a non-zero multiple of LANES");
        end
    endgenerate

    typedef enum logic {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               chg_q, chg_d;
    logic [WIDTH-1:0]   lane_mask;
    logic [WIDTH-1:0]   merged;

    // Expand the per-lane enables into a bit mask and form the shadow-with-writes merge.
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES_SAFE; i++) begin
            lane_mask[i*LW +: LW] = {LW{en[i]}};
        end
        merged = (sh_q & ~lane_mask) | (d & lane_mask);
    end

    // Next-state for q, shadow and the CLEAN/DIRTY FSM; clr overrides everything but reset.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        sh_d    = sh_q;

        if (DBUF == 0) begin
            // Direct mode: shadow mirrors q, commit is ignored, FSM parked in CLEAN.
            q_d     = (q_q & ~lane_mask) | (d & lane_mask);
            sh_d    = q_d;
            state_d = CLEAN;
        end else begin
            // Shadow always absorbs enabled lanes; commit publishes the merged value,
            // so a write presented alongside commit lands in q in the same edge.
            sh_d = merged;
            if (commit) begin
                q_d     = merged;
                state_d = CLEAN;
            end else if ((state_q == CLEAN) && (|en)) begin
                state_d = DIRTY;
            end
        end

        if (clr) begin
            q_d     = RESET_VAL;
            sh_d    = RESET_VAL;
            state_d = CLEAN;
        end

        // Pulse on any real change of q, including one caused by clr.
        chg_d = (q_d != q_q);
    end

    // State registers; reset discards any uncommitted shadow contents.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= CLEAN;
            q_q     <= RESET_VAL;
            sh_q    <= RESET_VAL;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sh_q    <= sh_d;
            chg_q   <= chg_d;
        end
    end

    assign q       = q_q;
    assign shadow  = sh_q;
    assign pending = (state_q == DIRTY);
    assign changed = chg_q;

endmodule

// File: tb/tb_j_slatchn.sv
// Directed bench for j_slatchn: direct mode, double-buffered mode, and clr with non-zero reset value.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_j_slatchn;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: direct mode, RESET_VAL=0
    logic        a_reset, a_commit, a_clr, a_pending, a_changed;
    logic [15:0] a_d, a_q, a_shadow;
    logic [1:0]  a_en;
    // Instance B: double-buffered, RESET_VAL=0
    logic        b_reset, b_commit, b_clr, b_pending, b_changed;
    logic [15:0] b_d, b_q, b_shadow;
    logic [1:0]  b_en;
    // Instance C: double-buffered, RESET_VAL=FFFF
    logic        c_reset, c_commit, c_clr, c_pending, c_changed;
    logic [15:0] c_d, c_q, c_shadow;
    logic [1:0]  c_en;

    j_slatchn #(.WIDTH(16), .LANES(2), .DBUF(0), .RESET_VAL(16'h0000)) u_dir (
        .sys_clk(sys_clk), .reset(a_reset), .d(a_d), .en(a_en), .commit(a_commit),
        .clr(a_clr), .q(a_q), .shadow(a_shadow), .pending(a_pending), .changed(a_changed));

    j_slatchn #(.WIDTH(16), .LANES(2), .DBUF(1), .RESET_VAL(16'h0000)) u_dbf (
        .sys_clk(sys_clk), .reset(b_reset), .d(b_d), .en(b_en), .commit(b_commit),
        .clr(b_clr), .q(b_q), .shadow(b_shadow), .pending(b_pending), .changed(b_changed));

    j_slatchn #(.WIDTH(16), .LANES(2), .DBUF(1), .RESET_VAL(16'hFFFF)) u_clr (
        .sys_clk(sys_clk), .reset(c_reset), .d(c_d), .en(c_en), .commit(c_commit),
        .clr(c_clr), .q(c_q), .shadow(c_shadow), .pending(c_pending), .changed(c_changed));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [15:0] eq, input logic ech);
        check({tag, ".q"}, {16'h0, a_q}, {16'h0, eq});
        check({tag, ".shadow"}, {16'h0, a_shadow}, {16'h0, eq});
        check({tag, ".pending"}, {31'h0, a_pending}, 32'h0);
        check({tag, ".changed"}, {31'h0, a_changed}, {31'h0, ech});
    endtask

    task automatic chk_b(input string tag, input logic [15:0] eq, input logic [15:0] es,
                         input logic ep, input logic ech);
        check({tag, ".q"}, {16'h0, b_q}, {16'h0, eq});
        check({tag, ".shadow"}, {16'h0, b_shadow}, {16'h0, es});
        check({tag, ".pending"}, {31'h0, b_pending}, {31'h0, ep});
        check({tag, ".changed"}, {31'h0, b_changed}, {31'h0, ech});
    endtask

    task automatic chk_c(input string tag, input logic [15:0] eq, input logic [15:0] es,
                         input logic ep, input logic ech);
        check({tag, ".q"}, {16'h0, c_q}, {16'h0, eq});
        check({tag, ".shadow"}, {16'h0, c_shadow}, {16'h0, es});
        check({tag, ".pending"}, {31'h0, c_pending}, {31'h0, ep});
        check({tag, ".changed"}, {31'h0, c_changed}, {31'h0, ech});
    endtask

    initial begin
        a_reset = 1'b1; a_d = '0; a_en = '0; a_commit = 1'b0; a_clr = 1'b0;
        b_reset = 1'b1; b_d = '0; b_en = '0; b_commit = 1'b0; b_clr = 1'b0;
        c_reset = 1'b1; c_d = '0; c_en = '0; c_commit = 1'b0; c_clr = 1'b0;
        tick();
        tick();
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        chk_a("a_rst", 16'h0000, 1'b0);
        chk_b("b_rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk_c("c_rst", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // ---- Direct mode ----
        a_d = 16'hA55A; a_en = 2'b01;
        tick();
        chk_a("a_lo", 16'h005A, 1'b1);
        a_d = 16'h1234; a_en = 2'b10;
        tick();
        chk_a("a_hi", 16'h125A, 1'b1);
        a_en = 2'b00; a_d = 16'hFFFF; a_commit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_a("a_hold", 16'h125A, 1'b0);
        end
        a_commit = 1'b0;
        a_en = 2'b11; a_d = 16'h125A;
        tick();
        chk_a("a_same", 16'h125A, 1'b0);
        a_en = 2'b11; a_d = 16'hBEEF;
        tick();
        chk_a("a_both", 16'hBEEF, 1'b1);
        a_en = 2'b00;
        tick();
        chk_a("a_idle", 16'hBEEF, 1'b0);

        // ---- Double-buffered: accumulate then commit ----
        b_en = 2'b01; b_d = 16'h00CD;
        tick();
        chk_b("b_acc1", 16'h0000, 16'h00CD, 1'b1, 1'b0);
        b_en = 2'b10; b_d = 16'hAB00;
        tick();
        chk_b("b_acc2", 16'h0000, 16'hABCD, 1'b1, 1'b0);
        b_en = 2'b00; b_commit = 1'b1;
        tick();
        chk_b("b_cmt", 16'hABCD, 16'hABCD, 1'b0, 1'b1);
        b_commit = 1'b0;
        tick();
        chk_b("b_post", 16'hABCD, 16'hABCD, 1'b0, 1'b0);
        // Same-cycle write + commit from CLEAN
        b_en = 2'b01; b_d = 16'h0011; b_commit = 1'b1;
        tick();
        chk_b("b_wc", 16'hAB11, 16'hAB11, 1'b0, 1'b1);
        // Identical commit
        b_en = 2'b00; b_commit = 1'b1;
        tick();
        chk_b("b_idc", 16'hAB11, 16'hAB11, 1'b0, 1'b0);
        // Set up q=2222, then DIRTY with shadow=1111
        b_en = 2'b11; b_d = 16'h2222; b_commit = 1'b1;
        tick();
        chk_b("b_set", 16'h2222, 16'h2222, 1'b0, 1'b1);
        b_d = 16'h1111; b_commit = 1'b0;
        tick();
        chk_b("b_dirty", 16'h2222, 16'h1111, 1'b1, 1'b0);
        // Reset mid-accumulation
        b_en = 2'b00; b_reset = 1'b1;
        tick();
        chk_b("b_mrst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        b_reset = 1'b0; b_commit = 1'b1;
        tick();
        chk_b("b_rcmt", 16'h0000, 16'h0000, 1'b0, 1'b0);
        b_commit = 1'b0;

        // ---- clr priority with RESET_VAL=FFFF ----
        c_en = 2'b11; c_d = 16'h1234; c_commit = 1'b1;
        tick();
        chk_c("c_set", 16'h1234, 16'h1234, 1'b0, 1'b1);
        c_en = 2'b01; c_d = 16'h0000; c_commit = 1'b0;
        tick();
        chk_c("c_dirty", 16'h1234, 16'h1200, 1'b1, 1'b0);
        c_clr = 1'b1; c_en = 2'b11; c_d = 16'h5555; c_commit = 1'b1;
        tick();
        chk_c("c_clr", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        tick();
        chk_c("c_clr2", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        c_clr = 1'b0; c_en = 2'b00; c_commit = 1'b0;
        tick();
        chk_c("c_idle", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
